// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants.
// FSM states, opcode fields, register widths.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    MUL_DONE = 2'd2
  } il_state_t;

endpackage

// File: rtl/pipeline_interlock_if.sv
// ID/EX hazard inputs and stall/flush/mul controls.
// Pipeline side is master, interlock is slave.
interface pipeline_interlock_if
  import pipe_pkg::*;
#(
  parameter int AW = REG_ADDR_W
);
  logic          id_valid;
  logic [AW-1:0] id_rs1;
  logic [AW-1:0] id_rs2;
  logic          id_use_rs1;
  logic          id_use_rs2;
  logic          id_is_multiply;
  logic          ex_valid;
  logic [AW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_is_hazard_0;
  logic          ex_branch_taken;
  logic          stall_if;
  logic          stall_id;
  logic          bubble_ex;
  logic          flush_if_id;
  logic          mul_start;
  logic          mul_busy;
  logic          mul_result_valid;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_use_rs1, id_use_rs2,
    output id_is_multiply,
    output ex_valid, ex_rd, ex_reg_write,
    output ex_is_hazard_0, ex_branch_taken,
    input  stall_if, stall_id, bubble_ex,
    input  flush_if_id, mul_start,
    input  mul_busy, mul_result_valid
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_use_rs1, id_use_rs2,
    input  id_is_multiply,
    input  ex_valid, ex_rd, ex_reg_write,
    input  ex_is_hazard_0, ex_branch_taken,
    output stall_if, stall_id, bubble_ex,
    output flush_if_id, mul_start,
    output mul_busy, mul_result_valid
  );
endinterface

// File: rtl/pipeline_interlock_hazard_compare.sv
// Late-result use comparator (load/ftoi in EX).
// Writes to x0 never count as a producer.
module hazard_compare
  import pipe_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          i_id_valid,
  input  logic          i_ex_valid,
  input  logic          i_ex_hazard,
  input  logic          i_ex_reg_write,
  input  logic [AW-1:0] i_ex_rd,
  input  logic [AW-1:0] i_rs1,
  input  logic [AW-1:0] i_rs2,
  input  logic          i_use_rs1,
  input  logic          i_use_rs2,
  output logic          o_hazard
);
  logic w_prod;
  logic w_m1;
  logic w_m2;

  assign w_prod = i_ex_valid & i_ex_hazard
                & i_ex_reg_write & (|i_ex_rd);
  assign w_m1 = i_use_rs1 & (i_rs1 == i_ex_rd);
  assign w_m2 = i_use_rs2 & (i_rs2 == i_ex_rd);
  assign o_hazard = i_id_valid & w_prod
                  & (w_m1 | w_m2);
endmodule

// File: rtl/pipeline_interlock.sv
// Hazard/stall sequencer: load-use bubble,
// fixed-latency multiply hold, branch flush.
module pipeline_interlock
  import pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int REG_ADDR_W  = pipe_pkg::REG_ADDR_W
) (
  input  logic clk,
  input  logic rstn,
  pipeline_interlock_if.slave bus
);
  localparam int CNT_W = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MUL_LATENCY - 1);

  il_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_busy;
  logic             r_rvalid;

  logic w_lu;
  logic w_br;
  logic w_idle;
  logic w_wait;
  logic w_issue;
  logic w_stall;

  hazard_compare #(
    .AW (REG_ADDR_W)
  ) u_hc (
    .i_id_valid     (bus.id_valid),
    .i_ex_valid     (bus.ex_valid),
    .i_ex_hazard    (bus.ex_is_hazard_0),
    .i_ex_reg_write (bus.ex_reg_write),
    .i_ex_rd        (bus.ex_rd),
    .i_rs1          (bus.id_rs1),
    .i_rs2          (bus.id_rs2),
    .i_use_rs1      (bus.id_use_rs1),
    .i_use_rs2      (bus.id_use_rs2),
    .o_hazard       (w_lu)
  );

  assign w_br   = bus.ex_branch_taken;
  assign w_idle = (r_state == IDLE);
  assign w_wait = (r_state == MUL_WAIT);

  // A redirect discards the fetched path, so it
  // beats both the load bubble and a mul issue.
  assign w_issue = w_idle & bus.id_valid
                 & bus.id_is_multiply
                 & ~w_lu & ~w_br;

  assign w_stall = rstn
                 & ((w_idle & w_lu & ~w_br) | w_wait);

  assign bus.stall_if         = w_stall;
  assign bus.stall_id         = w_stall;
  assign bus.bubble_ex        = w_stall;
  assign bus.flush_if_id      = rstn & w_br;
  assign bus.mul_start        = r_start;
  assign bus.mul_busy         = r_busy;
  assign bus.mul_result_valid = r_rvalid;

  // Multiply sequencer with registered controls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_rvalid <= 1'b0;
    end else begin
      r_start  <= 1'b0;
      r_rvalid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state <= MUL_WAIT;
            r_cnt   <= CNT_LOAD;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        MUL_WAIT: begin
          if (r_cnt == '0) begin
            r_state  <= MUL_DONE;
            r_busy   <= 1'b0;
            r_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        MUL_DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_interlock.sv
// Directed bench for pipeline_interlock with a
// cycle-count model checked on every negedge.
module tb_pipeline_interlock;
  localparam int L = 4;

  logic clk;
  logic rstn;
  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;
  int   k     = 0;

  pipeline_interlock_if #(.AW(5)) bus();

  pipeline_interlock #(
    .MUL_LATENCY (L),
    .REG_ADDR_W  (5)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic act,
                     input logic exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %b want %b",
                  nm, act, exp);
  endtask

  function automatic logic m_lu();
    logic hit;
    hit = (bus.id_use_rs1 &&
           bus.id_rs1 == bus.ex_rd) ||
          (bus.id_use_rs2 &&
           bus.id_rs2 == bus.ex_rd);
    return bus.id_valid && bus.ex_valid &&
           bus.ex_is_hazard_0 &&
           bus.ex_reg_write &&
           bus.ex_rd != 0 && hit;
  endfunction

  // k = cycles since the multiply issued; 0 idle.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) k <= 0;
    else if (k == 0) begin
      if (bus.id_valid && bus.id_is_multiply &&
          !m_lu() && !bus.ex_branch_taken)
        k <= 1;
    end else if (k == L + 1) k <= 0;
    else k <= k + 1;
  end

  always @(negedge clk) begin
    logic busy, st, br;
    busy = (k >= 1 && k <= L);
    br   = rstn && bus.ex_branch_taken;
    st   = rstn && (busy ||
           (k == 0 && m_lu() && !br));
    chk("m_stall_if", bus.stall_if, st);
    chk("m_stall_id", bus.stall_id, st);
    chk("m_bubble", bus.bubble_ex, st);
    chk("m_flush", bus.flush_if_id, br);
    chk("m_start", bus.mul_start, k == 1);
    chk("m_busy", bus.mul_busy, busy);
    chk("m_rvalid", bus.mul_result_valid,
        k == L + 1);
  end

  always @(posedge clk)
    if (rstn)
      assert (!(bus.mul_busy &&
                bus.ex_branch_taken))
      else $error("branch during MUL_WAIT");

  task automatic clr();
    bus.id_valid        = 0;
    bus.id_rs1          = 0;
    bus.id_rs2          = 0;
    bus.id_use_rs1      = 0;
    bus.id_use_rs2      = 0;
    bus.id_is_multiply  = 0;
    bus.ex_valid        = 0;
    bus.ex_rd           = 0;
    bus.ex_reg_write    = 0;
    bus.ex_is_hazard_0  = 0;
    bus.ex_branch_taken = 0;
  endtask

  task automatic load_ex(input logic [4:0] rd);
    bus.ex_valid       = 1;
    bus.ex_rd          = rd;
    bus.ex_reg_write   = 1;
    bus.ex_is_hazard_0 = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all0(input string nm);
    chk({nm, "_sif"}, bus.stall_if, 0);
    chk({nm, "_sid"}, bus.stall_id, 0);
    chk({nm, "_bub"}, bus.bubble_ex, 0);
    chk({nm, "_fl"}, bus.flush_if_id, 0);
    chk({nm, "_st"}, bus.mul_start, 0);
    chk({nm, "_bz"}, bus.mul_busy, 0);
    chk({nm, "_rv"}, bus.mul_result_valid, 0);
  endtask

  initial begin
    int s0, s1, ns;
    rstn = 0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk_all0("rst");
    rstn = 1;

    step();
    load_ex(5);
    bus.id_valid = 1;
    bus.id_rs1 = 5;
    bus.id_use_rs1 = 1;
    #1;
    chk("lu_sif", bus.stall_if, 1);
    chk("lu_sid", bus.stall_id, 1);
    chk("lu_bub", bus.bubble_ex, 1);
    step();
    bus.ex_valid = 0;
    #1;
    chk("lu_rel", bus.stall_if, 0);

    step();
    load_ex(0);
    bus.id_rs1 = 0;
    bus.id_rs2 = 0;
    bus.id_use_rs2 = 1;
    #1;
    chk("x0_sif", bus.stall_if, 0);

    step();
    load_ex(9);
    bus.id_rs1 = 3;
    bus.id_rs2 = 9;
    bus.id_use_rs2 = 0;
    #1;
    chk("noread", bus.stall_if, 0);
    step();
    bus.id_use_rs2 = 1;
    #1;
    chk("rs2_hit", bus.bubble_ex, 1);

    step();
    clr();
    load_ex(7);
    bus.id_valid = 1;
    bus.id_rs1 = 7;
    bus.id_use_rs1 = 1;
    bus.ex_branch_taken = 1;
    #1;
    chk("br_fl", bus.flush_if_id, 1);
    chk("br_sif", bus.stall_if, 0);
    chk("br_bub", bus.bubble_ex, 0);
    step();
    clr();
    bus.id_valid = 1;
    bus.id_is_multiply = 1;
    bus.ex_branch_taken = 1;
    #1;
    chk("br_nomul", bus.flush_if_id, 1);
    step();
    clr();
    #1;
    chk("br_nost", bus.mul_start, 0);

    step();
    bus.id_valid = 1;
    bus.id_is_multiply = 1;
    #1;
    chk("c0_st", bus.mul_start, 0);
    chk("c0_sif", bus.stall_if, 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 1) clr();
      #1;
      chk("mul_st", bus.mul_start, i == 1);
      chk("mul_bz", bus.mul_busy,
          i >= 1 && i <= 4);
      chk("mul_sif", bus.stall_if,
          i >= 1 && i <= 4);
      chk("mul_rv", bus.mul_result_valid,
          i == 5);
    end

    step();
    bus.id_valid = 1;
    bus.id_is_multiply = 1;
    ns = 0;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < 30 && ns < 2; i++) begin
      #1;
      if (bus.mul_start) begin
        if (ns == 0) s0 = cyc;
        else s1 = cyc;
        ns++;
      end
      step();
    end
    clr();
    ntot++;
    if (ns == 2 && s1 - s0 == 6) npass++;
    else $display("FAIL b2b: got %0d starts gap %0d want 2 gap 6",
                  ns, s1 - s0);
    repeat (8) step();

    bus.id_valid = 1;
    bus.id_is_multiply = 1;
    step();
    clr();
    step();
    #1;
    rstn = 0;
    load_ex(4);
    bus.id_valid = 1;
    bus.id_rs1 = 4;
    bus.id_use_rs1 = 1;
    bus.ex_branch_taken = 1;
    #1;
    chk_all0("mrst");
    step();
    clr();
    rstn = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      #1;
      chk("post_rv", bus.mul_result_valid, 0);
      chk("post_bz", bus.mul_busy, 0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
